// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the SRAM responder state type.
// Imported by the SRAM slave, its interface users and the bench.
package ahb_lite_pkg;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic [2:0] HsizeByte = 3'd0;
  localparam logic [2:0] HsizeHalf = 3'd1;
  localparam logic [2:0] HsizeWord = 3'd2;

  localparam logic [2:0] HburstSingle = 3'd0;
  localparam logic [2:0] HburstIncr   = 3'd1;
  localparam logic [2:0] HburstWrap4  = 3'd2;
  localparam logic [2:0] HburstIncr4  = 3'd3;
  localparam logic [2:0] HburstWrap8  = 3'd4;
  localparam logic [2:0] HburstIncr8  = 3'd5;
  localparam logic [2:0] HburstWrap16 = 3'd6;
  localparam logic [2:0] HburstIncr16 = 3'd7;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } slave_state_e;

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite signal bundle for one HSELx slot.
// The master modport also drives HREADY, standing in for the bus-level ready mux.
interface ahb_lite_sram_slave_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM: byte-enable synchronous write, asynchronous read.
// Contents are deliberately not reset.
module ahb_sram_mem #(
  parameter int unsigned MEM_WORDS = 1024,
  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic            clk,
  input  logic [3:0]      we,
  input  logic [IdxW-1:0] waddr,
  input  logic [31:0]     wdata,
  input  logic [IdxW-1:0] raddr,
  output logic [31:0]     rdata
);

  logic [31:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite responder backed by ahb_sram_mem: address/response FSM, optional
// wait states, two-cycle ERROR responses and little-endian byte-lane writes.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                  HCLK,
  input logic                  HRESET,
  ahb_lite_sram_slave_if.slave bus
);

  localparam int unsigned IdxW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MemBytes = 33'(MEM_WORDS) * 33'd4;

  slave_state_e     state_q;
  logic [3:0]       wait_cnt_q;
  logic [IdxW+1:0]  addr_q;
  logic             write_q;
  logic [2:0]       size_q;
  logic             err_q;
  logic             ready_q;
  logic             resp_q;

  logic             accept;
  logic             addr_err;
  logic [3:0]       byte_en;
  logic [31:0]      mem_rdata;

  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

  always_comb begin
    addr_err = 1'b0;
    if (bus.HSIZE > HsizeWord) addr_err = 1'b1;
    if ((bus.HSIZE == HsizeWord) && (bus.HADDR[1:0] != 2'b00)) addr_err = 1'b1;
    if ((bus.HSIZE == HsizeHalf) && bus.HADDR[0]) addr_err = 1'b1;
    if ({1'b0, bus.HADDR} >= MemBytes) addr_err = 1'b1;
  end

  // Only the idle-like states (IDLE, DATA, ERR2) may take a new address phase,
  // which gives back-to-back pipelining out of DATA and ERR2.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= 3'd0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      resp_q     <= HrespOkay;
    end else begin
      case (state_q)
        StWait: begin
          if (wait_cnt_q <= 4'd1) begin
            state_q    <= StData;
            wait_cnt_q <= 4'd0;
            ready_q    <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        StErr1: begin
          state_q <= StErr2;
          ready_q <= 1'b1;
          resp_q  <= HrespError;
        end
        default: begin
          if (accept) begin
            addr_q  <= bus.HADDR[IdxW+1:0];
            write_q <= bus.HWRITE;
            size_q  <= bus.HSIZE;
            err_q   <= addr_err;
            if (addr_err) begin
              state_q <= StErr1;
              ready_q <= 1'b0;
              resp_q  <= HrespError;
            end else if (WAIT_STATES == 0) begin
              state_q <= StData;
              ready_q <= 1'b1;
              resp_q  <= HrespOkay;
            end else begin
              state_q    <= StWait;
              wait_cnt_q <= 4'(WAIT_STATES);
              ready_q    <= 1'b0;
              resp_q     <= HrespOkay;
            end
          end else begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            resp_q  <= HrespOkay;
          end
        end
      endcase
    end
  end

  // Write commits on the edge that ends DATA, so a read accepted on that same
  // edge sees the new word through the asynchronous read port.
  always_comb begin
    byte_en = 4'b0000;
    if ((state_q == StData) && write_q && !err_q) begin
      case (size_q)
        HsizeByte: byte_en[addr_q[1:0]] = 1'b1;
        HsizeHalf: byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
        default:   byte_en = 4'b1111;
      endcase
    end
  end

  ahb_sram_mem #(
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk   (HCLK),
    .we    (byte_en),
    .waddr (addr_q[IdxW+1:2]),
    .wdata (bus.HWDATA),
    .raddr (addr_q[IdxW+1:2]),
    .rdata (mem_rdata)
  );

  assign bus.HREADYOUT = ready_q;
  assign bus.HRESP     = resp_q;
  assign bus.HRDATA    = ((state_q == StData) && !write_q) ? mem_rdata : 32'd0;

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
AHB-Lite responder (slave) backed by a word-addressed SRAM array. It is the memory end of the bus driven by the team's AHB-Lite master, and each HSELx slot in Top instantiates one. It supports single and burst (INCR/WRAP) transfers issued beat-by-beat by the master, configurable wait states, byte/halfword/word writes and two-cycle ERROR responses.

Parameters:
MEM_WORDS, 1024, depth of the SRAM in 32-bit words; valid byte addresses are 0 .. 4*MEM_WORDS-1.
WAIT_STATES, 0, number of HREADYOUT-low cycles inserted in every OKAY data phase (0..15).

Ports:
HCLK  input  1  bus clock; all state changes on rising edge.
HRESET  input  1  asynchronous, active-high reset.
HSEL  input  1  slave select from the decoder.
HADDR  input  32  byte address (address phase).
HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
HWRITE  input  1  1 = write, 0 = read.
HSIZE  input  3  0 byte, 1 halfword, 2 word; larger values are errors.
HWDATA  input  32  write data (data phase).
HREADY  input  1  bus-level ready (mux of all HREADYOUTs).
HREADYOUT  output  1  this slave's ready.
HRESP  output  1  0 OKAY, 1 ERROR.
HRDATA  output  32  read data, valid when HREADYOUT=1 in a read data phase.

Behaviour:
- Reset (async, HRESET=1): HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0, address-phase registers cleared. SRAM contents are not reset.
- Address phase accepted when HSEL & HREADY & HTRANS[1]=1 at a rising edge. On acceptance, register addr, write, size and error flag.
- HTRANS IDLE/BUSY, or HSEL=0, while HREADY=1: no transfer. The next cycle is zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Error condition, evaluated at acceptance:
  - HSIZE>2;
  - HSIZE=2 with HADDR[1:0]!=0;
  - HSIZE=1 with HADDR[0]=1;
  - HADDR >= 4*MEM_WORDS.
- States:
  - IDLE: no data phase pending.
  - WAIT: HREADYOUT=0, HRESP=0. Counter counts WAIT_STATES down to 1.
  - DATA: HREADYOUT=1, HRESP=0; final cycle of an OKAY transfer.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - Accepted and error -> ERR1 -> ERR2.
  - Accepted, no error, WAIT_STATES=0 -> DATA.
  - Accepted, no error, WAIT_STATES>0 -> WAIT (WAIT_STATES cycles) -> DATA.
  - Leaving DATA or ERR2: a new accepted transfer starts immediately (back-to-back pipelining). Otherwise -> IDLE.
  - A new address phase is only accepted while HREADY=1, so acceptance can never occur in WAIT or ERR1.
- Writes: committed at the rising edge ending DATA, using HWDATA sampled then. Lane enables are little-endian:
  - byte: lane HADDR[1:0];
  - halfword: lanes {HADDR[1],0} and {HADDR[1],1};
  - word: all four lanes.
  - Errored writes never modify memory.
- Reads: HRDATA = full 32-bit word at addr_q[log2(4*MEM_WORDS)-1:2] during DATA. The master extracts sub-word lanes. HRDATA is held at 0 outside a read DATA cycle.
- Write at address A followed back-to-back by a read of A: the read returns the new data, because the write commits on the same edge that accepts the read.
- Burst type is irrelevant to the slave. Each beat (NONSEQ/SEQ) is an independent transfer using the HADDR driven by the master, including the wrap back for WRAP4.
- Reset asserted mid-WAIT or mid-ERR: the transfer is aborted with no memory write and outputs go to reset values.

Decomposition:
- Shared package ahb_lite_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE codes;
  - HBURST codes (SINGLE/INCR/WRAP4/INCR4...);
  - HRESP OKAY/ERROR;
  - the slave state enum.
- One sub-module, ahb_sram_mem: MEM_WORDS x 32 array with a 4-bit byte-enable synchronous write port and an asynchronous read port.
- Address/response FSM and lane-enable generation stay in ahb_lite_sram_slave.

Test Plan:
- INCR4 write, WAIT_STATES=0: NONSEQ 0x3C, then SEQ 0x40/0x44/0x48 with data 60/64/68/72. Reading back 0x3C..0x48 -> HRDATA 60, 64, 68, 72, each with HREADYOUT=1 and HRESP=0 in the data phase.
- WRAP4 write at 0x64 (beats 0x64, 0x68, 0x6C, 0x60) with data 100/104/108/112. Reads of 0x60/0x64/0x68/0x6C -> 112/100/104/108.
- WAIT_STATES=2, word write 0x12345678 to 0x10, then read 0x10 -> exactly 2 HREADYOUT-low cycles per transfer; read returns 0x12345678.
- Byte write 0xAB at 0x11 over the word 0x12345678 -> read of 0x10 returns 0x1234AB78. Halfword 0xBEEF at 0x12 -> read returns 0xBEEFAB78.
- Unaligned word write at 0x02, and any access at 0x1000 (MEM_WORDS=1024) -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged on readback.
- WAIT_STATES=3: write 0xDEAD to 0x20 (old value 0x5), assert HRESET during the second wait cycle -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; read of 0x20 after reset returns 0x5.
